// File: rtl/bcm_oe_scheduler.sv
// bcm_oe_scheduler: binary-code-modulation OE scheduler (REQ -> ON -> BLANK per bit plane).
// Define OE_BRIGHTNESS_EN to add the BRIGHT port and scale the lit part of each on-window.
module bcm_oe_scheduler #(
  parameter int COLOR_DEPTH   = 4,
  parameter int LSB_ON_TIME   = 25000,
  parameter int BLANK_TIME    = 1200,
  parameter int OE_ACTIVE_LOW = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic LOAD_ACK,
`ifdef OE_BRIGHTNESS_EN
  input  logic [7:0] BRIGHT,
`endif
  output logic LOAD_REQ,
  output logic [((COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1)-1:0] PLANE,
  output logic OE,
  output logic PLANE_START,
  output logic FRAME_DONE
);

  localparam int     PW      = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
  localparam longint MAX_ON  = longint'(LSB_ON_TIME) << (COLOR_DEPTH - 1);
  localparam longint MAX_CNT = (MAX_ON > longint'(BLANK_TIME)) ? MAX_ON : longint'(BLANK_TIME);
  localparam int     CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [PW-1:0]    LAST_PLANE = PW'(COLOR_DEPTH - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_TIME - 1);
  localparam bit               BLANK_ONE  = (BLANK_TIME == 1);
  localparam logic             OE_ON      = (OE_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic             OE_OFF     = ~OE_ON;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ON, S_BLANK} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_dec;
  logic [CNT_W-1:0] on_len;
  logic             last_plane;

  always_comb begin
    on_len     = CNT_W'(LSB_ON_TIME) << PLANE;
    cnt_dec    = cnt - CNT_W'(1);
    last_plane = (PLANE == LAST_PLANE);
  end

`ifdef OE_BRIGHTNESS_EN
  localparam int PROD_W = CNT_W + 9;

  logic [PROD_W-1:0] lit_prod;
  logic [CNT_W-1:0]  lit_len;
  logic [CNT_W-1:0]  off_at;

  // OE stays lit while the down-counter is at or above off_at = ON_LEN - lit_len
  always_comb begin
    lit_prod = PROD_W'(on_len) * PROD_W'({1'b0, BRIGHT} + 9'd1);
    lit_len  = CNT_W'(lit_prod >> 8);
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      PLANE       <= '0;
      OE          <= OE_OFF;
      LOAD_REQ    <= 1'b0;
      PLANE_START <= 1'b0;
      FRAME_DONE  <= 1'b0;
`ifdef OE_BRIGHTNESS_EN
      off_at      <= '0;
`endif
    end else begin
      PLANE_START <= 1'b0;
      FRAME_DONE  <= 1'b0;
      case (state)
        S_IDLE: begin
          OE       <= OE_OFF;
          LOAD_REQ <= 1'b0;
          if (EN) state <= S_REQ;
        end
        S_REQ: begin
          if (LOAD_ACK) begin
            state       <= S_ON;
            LOAD_REQ    <= 1'b0;
            PLANE_START <= 1'b1;
            cnt         <= on_len - CNT_W'(1);
`ifdef OE_BRIGHTNESS_EN
            OE          <= (lit_len != '0) ? OE_ON : OE_OFF;
            off_at      <= on_len - lit_len;
`else
            OE          <= OE_ON;
`endif
          end else begin
            LOAD_REQ <= 1'b1;
          end
        end
        S_ON: begin
          if (cnt == '0) begin
            state <= S_BLANK;
            cnt   <= BLANK_LOAD;
            OE    <= OE_OFF;
            // a one-cycle blank makes its first cycle the frame's last one
            if (BLANK_ONE && last_plane) FRAME_DONE <= 1'b1;
          end else begin
            cnt <= cnt_dec;
`ifdef OE_BRIGHTNESS_EN
            OE  <= (cnt_dec >= off_at) ? OE_ON : OE_OFF;
`endif
          end
        end
        S_BLANK: begin
          if (cnt == '0) begin
            if (last_plane) begin
              PLANE    <= '0;
              state    <= EN ? S_REQ : S_IDLE;
              LOAD_REQ <= EN;
            end else begin
              PLANE    <= PLANE + PW'(1);
              state    <= S_REQ;
              LOAD_REQ <= 1'b1;
            end
          end else begin
            cnt <= cnt_dec;
            if (cnt == CNT_W'(1) && last_plane) FRAME_DONE <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
